stream_sorter: RTL and testbench
================================

# stream_sorter

- Block-at-a-time signed sorter built around a compare-exchange cell.
- Accepts a stream of DEPTH signed samples over a valid/ready handshake and stores them internally.
- Sorts them in descending order (maximum first, the same max-first ordering as the team's compare-exchange convention) using odd-even transposition, one phase per cycle.
- Streams the sorted block out over a second valid/ready handshake.
- Sits downstream of sample capture and upstream of rank/median selection logic.

## Interface
- DATA_WIDTH, 8, width of each signed sample.
- DEPTH, 8, samples per block; even, ≥2.
- Clk  input  1  clock, all state updates on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- InValid  input  1  upstream sample valid.
- InReady  output  1  block accepts a sample this cycle.
- InData  input  DATA_WIDTH  signed sample.
- OutValid  output  1  OutData holds a sorted sample.
- OutReady  input  1  downstream accepts OutData.
- OutData  output  DATA_WIDTH  sorted sample, largest first.
- OutLast  output  1  marks the final (smallest) sample of a block.
- Busy  output  1  high in SORT or DRAIN.

## Operation
- States: LOAD, SORT, DRAIN.
- **LOAD**
  - InReady=1.
  - On InValid&&InReady, store InData at array[LoadCount] and increment LoadCount.
  - On the DEPTH-th accept, go to SORT with PhaseCount=0.
- **SORT**
  - InReady=0.
  - Each cycle performs one phase.
    - Even PhaseCount: compare pairs (0,1),(2,3),…
    - Odd PhaseCount: compare pairs (1,2),(3,4),…,(DEPTH-3,DEPTH-2).
  - Within a pair, the larger value goes to the lower index.
  - Compare is signed.
  - Equal values are not swapped.
  - After DEPTH phases (PhaseCount=DEPTH-1 completing), go to DRAIN with OutIdx=0.
- **DRAIN**
  - OutValid=1, OutData=array[OutIdx], OutLast=(OutIdx==DEPTH-1).
  - On OutValid&&OutReady, increment OutIdx.
  - On the handshake with OutLast=1, go to LOAD with LoadCount=0.
- InValid is ignored outside LOAD.
- OutReady is ignored outside DRAIN.
- Values are never truncated or extended; storage is DATA_WIDTH bits per entry.
- Counters are sized to clog2(DEPTH) bits (minimum 1) and never wrap within a state.

## Timing
- **Reset values (nReset low, asynchronous):**
  - State=LOAD; LoadCount, PhaseCount and OutIdx = 0; array cleared to 0.
  - Outputs: InReady=1, OutValid=0, OutData=0, OutLast=0, Busy=0.
  - Samples presented while nReset is low are not captured.
- **Latency:**
  - Last input accepted at edge t.
  - SORT occupies cycles t+1 … t+DEPTH.
  - OutValid rises after edge t+DEPTH (first sample available DEPTH cycles after the last accept).
- **Throughput:** one block per DEPTH (load) + DEPTH (sort) + DEPTH (drain, no stall) cycles; no overlap between blocks.
- **Backpressure:** while OutValid=1 and OutReady=0, OutData and OutLast hold stable.
- **Last-drain/LOAD boundary:**
  - InReady rises in the cycle after the final output handshake.
  - No sample is accepted in the same cycle as the last output.
- **Reset mid-operation (any state):** discard stored data and return to LOAD with reset values; no partial block is emitted.
- **Output decode:** OutValid, InReady and Busy are decoded from registered state only, with no combinational path from InValid or OutReady.

## Structure
- **Shared include (stream_sorter_defs.vh, `ifndef-guarded):**
  - State encodings ST_LOAD/ST_SORT/ST_DRAIN (2-bit).
  - A clog2-style constant function for counter width.
- **Sub-module compare_exchange_cell:**
  - Combinational, parameter DATA_WIDTH.
  - Inputs: signed A, B, Enable.
  - Outputs: Hi, Lo.
    - Enable=0: pass-through.
    - Enable=1: Hi=max, Lo=min; A retained on tie.
  - DEPTH-1 instances are generated over adjacent pairs; instance k is enabled when the pair index parity matches PhaseCount parity.
- Top level holds the FSM, counters, sample array and output mux.

## Test plan
- **Basic block, DEPTH=8, DATA_WIDTH=8:**
  - Stimulus: 3,-1,7,0,-128,127,5,5 with OutReady=1.
  - Required: OutData 127,7,5,5,3,0,-1,-128; OutLast only on -128; first OutValid exactly 8 cycles after the last accept; Busy high from SORT entry through the last handshake.
- **Ordering extremes:**
  - Stimulus: ascending -4..3.
  - Required: output 3..-4.
  - Stimulus: already-descending input.
  - Required: unchanged order.
  - Stimulus: all inputs 42.
  - Required: eight 42s.
- **Backpressure:**
  - Stimulus: OutReady pseudo-random 30% high.
  - Required: each sorted value appears exactly once in order; OutData/OutLast stable across every stalled cycle.
- **Input gating and back-to-back blocks:**
  - Stimulus: InValid held high continuously with two blocks queued.
  - Required: InReady=0 during SORT/DRAIN; no sample lost or captured early; second block sorted independently.
- **Reset mid-operation:**
  - Stimulus: nReset pulsed low during SORT phase 3, then during DRAIN after 2 outputs.
  - Required: outputs return to reset values immediately; no further OutValid; the next full block sorts correctly.
- **DEPTH=2 boundary:**
  - Stimulus: -128 then 127.
  - Required: output 127,-128 with OutLast on -128.

Source files
------------

// File: rtl/stream_sorter_pkg.sv
// Shared types and helpers for the block sorter: FSM state encoding and counter sizing.
package stream_sorter_pkg;

   typedef enum logic [1:0] {
      StLoad  = 2'd0,
      StSort  = 2'd1,
      StDrain = 2'd2
   } state_e;

   // Index counter width: ceil(log2(n)), never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/compare_exchange_cell.sv
// Signed compare-exchange: when enabled, Hi gets the larger operand and Lo the smaller.
module compare_exchange_cell #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic signed [DATA_WIDTH-1:0] A,
   input  logic signed [DATA_WIDTH-1:0] B,
   input  logic                         Enable,
   output logic signed [DATA_WIDTH-1:0] Hi,
   output logic signed [DATA_WIDTH-1:0] Lo
);

   logic swap;

   // Strict compare keeps A in the Hi slot on a tie.
   assign swap = Enable && (B > A);
   assign Hi   = swap ? B : A;
   assign Lo   = swap ? A : B;

endmodule

// File: rtl/stream_sorter.sv
// Block-at-a-time descending sorter: load DEPTH samples, run DEPTH odd-even
// transposition phases, then stream the block out largest first.
module stream_sorter
   import stream_sorter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                         Clk,
   input  logic                         nReset,
   input  logic                         InValid,
   output logic                         InReady,
   input  logic signed [DATA_WIDTH-1:0] InData,
   output logic                         OutValid,
   input  logic                         OutReady,
   output logic signed [DATA_WIDTH-1:0] OutData,
   output logic                         OutLast,
   output logic                         Busy
);

   localparam int unsigned CntW = cnt_width(DEPTH);
   localparam logic [CntW-1:0] LastIdx = CntW'(DEPTH - 1);

   state_e state_q, state_d;
   logic [CntW-1:0] load_cnt_q, load_cnt_d;
   logic [CntW-1:0] phase_q, phase_d;
   logic [CntW-1:0] out_idx_q, out_idx_d;

   logic signed [DATA_WIDTH-1:0] arr_q [DEPTH];
   logic signed [DATA_WIDTH-1:0] arr_d [DEPTH];
   logic signed [DATA_WIDTH-1:0] cx_hi [DEPTH-1];
   logic signed [DATA_WIDTH-1:0] cx_lo [DEPTH-1];
   logic [DEPTH-2:0]             cx_en;

   // Cell k spans (k, k+1); even cells fire on even phases, odd cells on odd phases.
   for (genvar k = 0; k < DEPTH - 1; k++) begin : g_cx
      assign cx_en[k] = (state_q == StSort) && (phase_q[0] == 1'(k % 2));

      compare_exchange_cell #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_cx (
         .A     (arr_q[k]),
         .B     (arr_q[k+1]),
         .Enable(cx_en[k]),
         .Hi    (cx_hi[k]),
         .Lo    (cx_lo[k])
      );
   end

   assign InReady  = (state_q == StLoad);
   assign OutValid = (state_q == StDrain);
   assign Busy     = (state_q != StLoad);
   assign OutLast  = OutValid && (out_idx_q == LastIdx);
   assign OutData  = OutValid ? arr_q[out_idx_q] : '0;

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      phase_d    = phase_q;
      out_idx_d  = out_idx_q;
      arr_d      = arr_q;

      unique case (state_q)
         StLoad: begin
            if (InValid) begin
               arr_d[load_cnt_q] = InData;
               if (load_cnt_q == LastIdx) begin
                  state_d = StSort;
                  phase_d = '0;
               end else begin
                  load_cnt_d = load_cnt_q + CntW'(1);
               end
            end
         end
         StSort: begin
            for (int k = 0; k < int'(DEPTH) - 1; k++) begin
               if (cx_en[k]) begin
                  arr_d[k]   = cx_hi[k];
                  arr_d[k+1] = cx_lo[k];
               end
            end
            if (phase_q == LastIdx) begin
               state_d   = StDrain;
               out_idx_d = '0;
            end else begin
               phase_d = phase_q + CntW'(1);
            end
         end
         StDrain: begin
            if (OutReady) begin
               if (out_idx_q == LastIdx) begin
                  state_d    = StLoad;
                  load_cnt_d = '0;
               end else begin
                  out_idx_d = out_idx_q + CntW'(1);
               end
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q    <= StLoad;
         load_cnt_q <= '0;
         phase_q    <= '0;
         out_idx_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            arr_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         phase_q    <= phase_d;
         out_idx_q  <= out_idx_d;
         arr_q      <= arr_d;
      end
   end

endmodule

// File: tb/tb_stream_sorter.sv
// Scoreboard bench for stream_sorter: DEPTH=8 main instance plus a DEPTH=2 boundary instance.
module tb_stream_sorter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              n_reset;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic signed [7:0] out_data;
   logic              out_last;
   logic              busy;

   logic              in_valid2;
   logic              in_ready2;
   logic signed [7:0] in_data2;
   logic              out_valid2;
   logic              out_ready2;
   logic signed [7:0] out_data2;
   logic              out_last2;
   logic              busy2;

   stream_sorter #(.DATA_WIDTH(8), .DEPTH(8)) dut (
      .Clk(clk), .nReset(n_reset),
      .InValid(in_valid), .InReady(in_ready), .InData(in_data),
      .OutValid(out_valid), .OutReady(out_ready), .OutData(out_data),
      .OutLast(out_last), .Busy(busy)
   );

   stream_sorter #(.DATA_WIDTH(8), .DEPTH(2)) dut2 (
      .Clk(clk), .nReset(n_reset),
      .InValid(in_valid2), .InReady(in_ready2), .InData(in_data2),
      .OutValid(out_valid2), .OutReady(out_ready2), .OutData(out_data2),
      .OutLast(out_last2), .Busy(busy2)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pops   = 0;

   logic signed [7:0] tx_q[$];
   logic signed [7:0] exp_q[$];
   bit                explast_q[$];

   bit                rand_ready = 1'b0;
   bit                prev_stall = 1'b0;
   logic signed [7:0] held_data;
   logic              held_last;

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, want);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 9) < 3);
   end

   // Output monitor: compares every handshake against the scoreboard and checks stall stability.
   always @(negedge clk) begin
      if (!n_reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_data", int'(out_data), int'(held_data));
            check("stall_last", int'(out_last), int'(held_last));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", int'(out_valid), 0);
            end else begin
               check("out_data", int'(out_data), int'(exp_q.pop_front()));
               check("out_last", int'(out_last), int'(explast_q.pop_front()));
               pops++;
            end
         end
         prev_stall = out_valid && !out_ready;
         held_data  = out_data;
         held_last  = out_last;
      end
   end

   task automatic queue_block(input logic signed [7:0] v [8]);
      logic signed [7:0] s [8];
      s = v;
      for (int i = 0; i < 8; i++) tx_q.push_back(v[i]);
      for (int i = 1; i < 8; i++) begin
         logic signed [7:0] key;
         int j;
         key = s[i];
         j = i - 1;
         while (j >= 0 && s[j] < key) begin
            s[j+1] = s[j];
            j--;
         end
         s[j+1] = key;
      end
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(s[i]);
         explast_q.push_back(i == 7);
      end
   endtask

   // Holds in_valid high until every queued sample is accepted; call at #1 after a rising edge.
   task automatic send_all();
      int guard;
      bit acc;
      guard = 0;
      while (tx_q.size() > 0 && guard < 2000) begin
         in_valid = 1'b1;
         in_data  = tx_q[0];
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         guard++;
         if (acc) void'(tx_q.pop_front());
      end
      in_valid = 1'b0;
      check("send_timeout", tx_q.size(), 0);
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 1000) begin
         @(posedge clk);
         guard++;
      end
      check("drain_timeout", exp_q.size(), 0);
      @(negedge clk);
      check("inready_after_drain", int'(in_ready), 1);
      check("outvalid_after_drain", int'(out_valid), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_inready"}, int'(in_ready), 1);
      check({tag, "_outvalid"}, int'(out_valid), 0);
      check({tag, "_outdata"}, int'(out_data), 0);
      check({tag, "_outlast"}, int'(out_last), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   task automatic pulse_reset(input string tag);
      n_reset = 1'b0;
      #1;
      check_reset_outputs(tag);
      exp_q.delete();
      explast_q.delete();
      in_valid = 1'b1;
      in_data  = 8'sd55;
      repeat (3) begin
         @(posedge clk);
         #1;
         check({tag, "_held"}, int'(out_valid), 0);
      end
      in_valid = 1'b0;
      n_reset  = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check({tag, "_after"}, int'(out_valid), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got %0d expected %0d", cyc, 0);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int base;
      int guard;

      n_reset    = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b1;
      in_valid2  = 1'b0;
      in_data2   = '0;
      out_ready2 = 1'b1;
      #12;
      check_reset_outputs("reset");
      check("reset_busy2", int'(busy2), 0);
      @(posedge clk);
      #1;
      n_reset = 1'b1;
      @(posedge clk);
      #1;

      // Basic block with latency and busy checks.
      queue_block('{3, -1, 7, 0, -128, 127, 5, 5});
      send_all();
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (out_valid) break;
         check("busy_sort", int'(busy), 1);
         check("inready_sort", int'(in_ready), 0);
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", n, 8);
      @(posedge clk);
      #1;
      wait_drain();

      // Ordering extremes.
      queue_block('{-4, -3, -2, -1, 0, 1, 2, 3});
      send_all();
      wait_drain();
      queue_block('{100, 50, 20, 10, 0, -10, -50, -100});
      send_all();
      wait_drain();
      queue_block('{42, 42, 42, 42, 42, 42, 42, 42});
      send_all();
      wait_drain();

      // Backpressure.
      rand_ready = 1'b1;
      queue_block('{10, -20, 30, -40, 50, -60, 70, -80});
      send_all();
      wait_drain();
      rand_ready = 1'b0;
      out_ready  = 1'b1;

      // Two blocks with in_valid held high throughout.
      queue_block('{1, 9, -3, 4, 4, -7, 0, 2});
      queue_block('{-1, -9, 3, -4, 6, 7, -128, 127});
      send_all();
      wait_drain();

      // Reset during SORT phase 3.
      queue_block('{5, 4, 3, 2, 1, 0, -1, -2});
      send_all();
      repeat (3) @(posedge clk);
      #1;
      check("sort_busy_pre_reset", int'(busy), 1);
      pulse_reset("rst_sort");
      queue_block('{8, -8, 16, -16, 32, -32, 64, -64});
      send_all();
      wait_drain();

      // Reset during DRAIN after two outputs.
      queue_block('{11, 22, 33, 44, 55, 66, 77, 88});
      base = pops;
      send_all();
      guard = 0;
      while (pops < base + 2 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      check("drain_two_pops", pops - base, 2);
      #1;
      pulse_reset("rst_drain");
      queue_block('{-5, 15, -25, 35, -45, 55, -65, 75});
      send_all();
      wait_drain();

      // DEPTH=2 boundary instance.
      in_valid2 = 1'b1;
      in_data2  = -8'sd128;
      @(posedge clk);
      #1;
      in_data2 = 8'sd127;
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (out_valid2) break;
         @(posedge clk);
         #1;
         n++;
      end
      check("d2_latency", n, 2);
      check("d2_data0", int'(out_data2), 127);
      check("d2_last0", int'(out_last2), 0);
      @(negedge clk);
      check("d2_data1", int'(out_data2), -128);
      check("d2_last1", int'(out_last2), 1);
      @(negedge clk);
      check("d2_valid_end", int'(out_valid2), 0);
      check("d2_ready_end", int'(in_ready2), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
